// File: rtl/key_pio_pkg.sv
// rtl/key_pio_pkg.sv - shared register map and sizing helpers for the key input port
package key_pio_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    function automatic int debounce_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, inversion and debounce counter
module key_debounce
    import key_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int              CW       = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          pressed;
    logic [CW-1:0] cnt;

    assign pressed = ~sync2;

    // press is a registered pulse, high during the first cycle level reads 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (pressed == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= pressed;
                press <= pressed;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_input_pio.sv
// rtl/key_input_pio.sv - Avalon-MM push-button port with edge capture, irq and press counter
module key_input_pio
    import key_pio_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] mask_reg;
    logic [N_KEYS-1:0] edge_reg;
    logic [N_KEYS-1:0] edge_clr;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  press_cnt;
    logic [31:0]       rd_mux;
    logic              wr_mask;
    logic              wr_edge;
    logic              wr_count;
    logic              unused_wdata;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .key_n  (key_n[i]),
            .level  (level[i]),
            .press  (press[i])
        );
    end

    always_comb begin
        press_cnt = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            press_cnt = press_cnt + CNT_W'(press[i]);
        end
    end

    assign wr_mask      = write && (address == ADDR_MASK);
    assign wr_edge      = write && (address == ADDR_EDGE);
    assign wr_count     = write && (address == ADDR_COUNT);
    assign edge_clr     = wr_edge ? writedata[N_KEYS-1:0] : '0;
    assign unused_wdata = ^writedata;

    // a new press always outranks a same-cycle clear, both for EDGE and COUNT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg  <= '0;
            edge_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (wr_mask) begin
                mask_reg <= writedata[N_KEYS-1:0];
            end
            edge_reg  <= (edge_reg & ~edge_clr) | press;
            count_reg <= (wr_count ? '0 : count_reg) + press_cnt;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:  rd_mux[N_KEYS-1:0] = level;
            ADDR_MASK:  rd_mux[N_KEYS-1:0] = mask_reg;
            ADDR_EDGE:  rd_mux[N_KEYS-1:0] = edge_reg;
            ADDR_COUNT: rd_mux[CNT_W-1:0]  = count_reg;
            default:    rd_mux             = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_reg & mask_reg);

endmodule

// File: tb/tb_key_input_pio.sv
// tb/tb_key_input_pio.sv - randomized self-checking bench for key_input_pio
module tb_key_input_pio;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [1:0]    address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic          irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_input_pio #(
        .N_KEYS         (NK),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .key_n    (key_n),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .irq      (irq)
    );

    // hist[j] holds the pressed vector sampled j+1 edges ago
    logic [NK-1:0] hist [0:DB];
    logic [NK-1:0] m_state;
    logic [NK-1:0] m_press;
    logic [NK-1:0] m_mask;
    logic [NK-1:0] m_edge;
    logic [CW-1:0] m_count;
    logic [31:0]   m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_state);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_edge);
            default: return 32'(m_count);
        endcase
    endfunction

    task automatic model_reset();
        for (int j = 0; j <= DB; j++) hist[j] = '0;
        m_state = '0;
        m_press = '0;
        m_mask  = '0;
        m_edge  = '0;
        m_count = '0;
        m_rd    = '0;
    endtask

    // A key's accepted level flips once the synchronised samples of the last DB
    // cycles all disagree with it; a 0->1 flip counts as a press one cycle later.
    task automatic model_edge();
        logic [NK-1:0] flip;
        int            pc;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (read) m_rd = m_reg(address);
        pc = $countones(m_press);
        if (write && address == 2'd1) m_mask = writedata[NK-1:0];
        if (write && address == 2'd2) m_edge = m_edge & ~writedata[NK-1:0];
        m_edge = m_edge | m_press;
        if (write && address == 2'd3) m_count = '0;
        m_count = m_count + CW'(pc);
        flip = '0;
        for (int k = 0; k < NK; k++) begin
            bit all_diff = 1'b1;
            for (int j = 1; j <= DB; j++) begin
                if (hist[j][k] == m_state[k]) all_diff = 1'b0;
            end
            flip[k] = all_diff;
        end
        m_press = flip & ~m_state;
        m_state = m_state ^ flip;
        for (int j = DB; j >= 1; j--) hist[j] = hist[j-1];
        hist[0] = ~key_n;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("readdata", readdata, m_rd);
        chk("irq", 32'(irq), 32'(|(m_edge & m_mask)));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        read    = 1'b1;
        step();
        read    = 1'b0;
        chk(name, readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        step();
        write     = 1'b0;
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
    endtask

    initial begin
        model_reset();
        steps(2);
        reset_n = 1'b1;
        step();

        rd("reset_data", 2'd0, 32'h0);
        rd("reset_mask", 2'd1, 32'h0);
        rd("reset_edge", 2'd2, 32'h0);
        rd("reset_count", 2'd3, 32'h0);
        chk("reset_irq_lit", 32'(irq), 32'h0);

        key_n[1] = 1'b0;
        steps(3);
        key_n[1] = 1'b1;
        steps(8);
        rd("glitch_data", 2'd0, 32'h0);
        rd("glitch_edge", 2'd2, 32'h0);
        rd("glitch_count", 2'd3, 32'h0);

        key_n[1] = 1'b0;
        steps(5);
        rd("press_data_early", 2'd0, 32'h0);
        rd("press_data", 2'd0, 32'h2);
        rd("press_edge", 2'd2, 32'h2);
        rd("press_count", 2'd3, 32'h1);
        chk("masked_irq", 32'(irq), 32'h0);

        wr(2'd1, 32'h2);
        chk("irq_on_mask", 32'(irq), 32'h1);
        wr(2'd2, 32'h2);
        chk("irq_off_w1c", 32'(irq), 32'h0);
        rd("edge_cleared", 2'd2, 32'h0);

        key_n[3:2] = 2'b00;
        steps(10);
        rd("dual_count", 2'd3, 32'h3);

        key_n = '1;
        steps(10);
        key_n[0] = 1'b0;
        steps(6);
        wr(2'd3, 32'h0);
        rd("count_clr_collide", 2'd3, 32'h1);

        key_n[0] = 1'b1;
        steps(10);
        key_n[0] = 1'b0;
        steps(6);
        wr(2'd2, 32'h1);
        rd("edge_w1c_collide", 2'd2, 32'hD);

        wr(2'd1, 32'hF);
        chk("irq_before_reset", 32'(irq), 32'h1);
        key_n[0] = 1'b1;
        steps(10);
        key_n[0] = 1'b0;
        steps(3);
        async_reset();
        steps(2);
        reset_n = 1'b1;
        steps(5);
        rd("requal_data_early", 2'd0, 32'h0);
        rd("requal_data", 2'd0, 32'h1);
        rd("requal_edge", 2'd2, 32'h1);

        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 5) == 0) key_n[k] = ~key_n[k];
            end
            read      = ($urandom_range(0, 2) == 0);
            write     = ($urandom_range(0, 3) == 0);
            address   = 2'($urandom_range(0, 3));
            writedata = $urandom;
            if ($urandom_range(0, 999) == 0) begin
                async_reset();
                step();
                reset_n = 1'b1;
            end
            step();
        end
        read  = 1'b0;
        write = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_input_pio.md
Name: key_input_pio

Overview:
- Avalon-MM responder that brings the board push-buttons into the Nios II processor. It is the input-side counterpart to the 24-bit hex output port.
- Synchronises and debounces each active-low key, then exposes key state to software: live levels, sticky press-edge capture, a maskable interrupt and a running press counter.
- Sits inside the platform as a custom component on the Nios data master. Its key inputs are exported to the board top level.

Parameters:
- N_KEYS, 4, number of key inputs (1..8).
- DEBOUNCE_CYCLES, 500000, cycles a synchronised level must hold before acceptance (10 ms at 50 MHz). Must be >= 2.
- CNT_W, 16, press-counter width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- key_n  in  N_KEYS  raw board keys, active-low, asynchronous to clk.
- address  in  2  word address.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, fixed read latency 1.
- irq  out  1  level interrupt to Nios.

Behaviour:
- Reset is asynchronous on reset_n low; all flops are cleared immediately. Reset values:
  - synchroniser flops = 1 (released);
  - debounced state = 0 (not pressed);
  - debounce counters, edge, mask, count = 0;
  - readdata = 0, irq = 0.
- Synchronisation: 2-FF synchroniser per key, then inverted so that pressed = 1.
- Debounce, per key:
  - If the synchronised level equals the debounced state, clear the counter.
  - Otherwise increment the counter. When it reaches DEBOUNCE_CYCLES-1, update the debounced state on that cycle and clear the counter.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes state.
- Press event: debounced bit goes 0->1 on cycle N. Release events are not captured.
- Register map (unused bits read 0):
  - 0 DATA (RO): debounced state [N_KEYS-1:0]. Writes ignored.
  - 1 MASK (RW): irq enable [N_KEYS-1:0].
  - 2 EDGE (RW1C): sticky press capture. Writing 1 clears the bit; writing 0 has no effect.
  - 3 COUNT (RO, write clears): total press events, CNT_W bits, wraps mod 2^CNT_W.
- Edge/count timing: an event on cycle N sets the EDGE bit and adds to COUNT, both visible from N+1.
  - Simultaneous presses on several keys in one cycle add their popcount to COUNT.
- Simultaneous events:
  - EDGE set and W1C clear on the same bit in the same cycle: set wins, bit stays 1.
  - COUNT write-clear and a press in the same cycle: COUNT becomes that cycle's popcount.
- irq = |(EDGE & MASK), driven combinationally from registers.
  - Asserts on N+1 after an enabled press.
  - Deasserts the cycle after the clearing write.
  - Setting MASK over an already-set EDGE bit raises irq the next cycle.
- Read timing: read asserted on cycle R gives readdata valid on R+1. readdata holds its last value otherwise.
  - A read of EDGE does not clear it.
  - read and write together in one cycle: the write takes effect, and readdata returns the pre-write value.
- No wait states; waitrequest is not used.
- Reset mid-debounce discards partial counts; a key held through reset re-qualifies after DEBOUNCE_CYCLES.

Decomposition:
- Shared package key_pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_COUNT=3;
  - default DEBOUNCE_CYCLES;
  - counter-width helper (clog2 of DEBOUNCE_CYCLES).
- One sub-module, key_debounce, instantiated N_KEYS times.
  - Contains the synchroniser, inversion and counter.
  - Outputs debounced level and a one-cycle press pulse.
- The top holds the register file, popcount adder, irq and read mux.

Test Plan:
- Set DEBOUNCE_CYCLES=4. Reset, then read all four registers -> DATA=0, MASK=0, EDGE=0, COUNT=0, irq=0.
- Drive key_n[1] low for 3 cycles then high -> DATA stays 0, EDGE=0, COUNT=0 (glitch rejected).
- Drive key_n[1] low steadily -> DATA=0x2 after 2 sync + 4 debounce cycles, EDGE=0x2, COUNT=1. irq stays 0 while MASK=0.
- Write MASK=0x2 -> irq=1 next cycle. Write EDGE=0x2 -> irq=0 next cycle, EDGE=0.
- Press key_n[2] and key_n[3] together -> COUNT increases by 2 in a single cycle. COUNT written while a press qualifies -> COUNT=1. W1C on EDGE colliding with a new press on the same key -> bit remains 1.
- Assert reset_n low mid-debounce with key_n[0] held low -> all outputs 0 immediately. After release, DATA[0]=1 only after the full 2+4 cycles, and EDGE[0] sets.
